// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: owns the PC, reads a combinational instruction
// memory and hands {pc, instr} to decode through a 2-entry valid/ready buffer.
//
// state | meaning
// EMPTY | no buffered instruction, out_valid=0
// ONE   | one entry at head
// FULL  | two entries, fetch stalls unless head pops this cycle
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        head, tail;
  logic [31:0] buf_pc    [BUF_DEPTH];
  logic [31:0] buf_instr [BUF_DEPTH];

  logic pop, push, pc_oor, redir_bad;

  always_comb begin
    pop       = out_valid & out_ready;
    pc_oor    = (pc[31:2] >= DEPTH_W);
    redir_bad = (redirect_pc[1:0] != 2'b00) | (redirect_pc[31:2] >= DEPTH_W);
    // redirect and fault both block fetch; a pop frees a slot in the same cycle
    push      = ~redirect_valid & ~fault & ~pc_oor & ((state != FULL) | pop);
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = EMPTY;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (state == EMPTY) state_nxt = ONE;
          else                state_nxt = FULL;
        end
        2'b01: begin
          if (state == FULL) state_nxt = ONE;
          else               state_nxt = EMPTY;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      head        <= 1'b0;
      tail        <= 1'b0;
      pc          <= RESET_PC;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        head  <= 1'b0;
        tail  <= 1'b0;
        pc    <= redirect_pc;
        fault <= redir_bad;
      end else begin
        if (pop) head <= ~head;
        if (push) begin
          tail        <= ~tail;
          pc          <= pc + 32'd4;
          fetch_count <= fetch_count + 32'd1;
        end
        if (pc_oor) fault <= 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only visible while out_valid=1.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[tail]    <= pc;
      buf_instr[tail] <= imem_instruction;
    end
  end

  always_comb begin
    imem_addr = pc;
    out_valid = (state != EMPTY);
    out_instr = out_valid ? buf_instr[head] : 32'd0;
    out_pc    = out_valid ? buf_pc[head]    : 32'd0;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected {pc, instr}
// checked on every handshake, a redirect vector table, and corner sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, fetch_count;
  logic        fault;

  logic [31:0] s_imem_addr, s_imem_instruction;
  logic        s_redirect_valid = 1'b0;
  logic [31:0] s_redirect_pc = 32'd0;
  logic        s_out_valid, s_out_ready = 1'b0;
  logic [31:0] s_out_instr, s_out_pc, s_fetch_count;
  logic        s_fault;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] rpc;
    logic        exp_fault;
  } redir_vec_t;

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [29:0] idx);
    case (idx)
      30'd0:   return 32'h0050_0093;
      30'd1:   return 32'h00a0_0113;
      30'd2:   return 32'h0020_81b3;
      default: return {16'hC0DE, idx[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a, input int depth);
    if (a[31:2] < 30'(depth)) return img(a[31:2]);
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_instruction   = mem_read(imem_addr, 256);
  assign s_imem_instruction = mem_read(s_imem_addr, 4);

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(256), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .fault(fault), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .BUF_DEPTH(2)) u_small (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(s_imem_addr), .imem_instruction(s_imem_instruction),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_instr(s_out_instr), .out_pc(s_out_pc),
    .fault(s_fault), .fetch_count(s_fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_from(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = pc0 + 32'(4 * i);
      e.instr = img(e.pc[31:2]);
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Handshake observed at negedge completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pop_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
      end
    end
  end

  redir_vec_t rtab[7];

  initial begin
    logic [31:0] fc;

    rtab[0] = '{32'h0000_0008, 1'b0};
    rtab[1] = '{32'h0000_0006, 1'b1};
    rtab[2] = '{32'h0000_0000, 1'b0};
    rtab[3] = '{32'h0000_03F0, 1'b0};
    rtab[4] = '{32'h0000_0400, 1'b1};
    rtab[5] = '{32'h0000_0001, 1'b1};
    rtab[6] = '{32'hFFFF_FFFC, 1'b1};

    // Reset values and full-rate streaming
    out_ready = 1'b1;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fcount", fetch_count, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    do_reset();
    expect_from(32'h0, 16);
    step();
    check("lat1_valid", {31'd0, out_valid}, 32'd1);
    check("lat1_pc", out_pc, 32'h0);
    check("lat1_instr", out_instr, 32'h0050_0093);
    step();
    check("stream_valid2", {31'd0, out_valid}, 32'd1);
    check("stream_pc2", out_pc, 32'h4);
    step();
    check("stream_valid3", {31'd0, out_valid}, 32'd1);
    check("stream_pc3", out_pc, 32'h8);
    check("fcount3", fetch_count, 32'd3);

    // Back-pressure: buffer fills and holds, then drains back-to-back
    out_ready = 1'b0;
    do_reset();
    expect_from(32'h0, 16);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_pc", out_pc, 32'h0);
      check("bp_instr", out_instr, 32'h0050_0093);
    end
    check("bp_addr", imem_addr, 32'h8);
    check("bp_fcount", fetch_count, 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("drain_valid", {31'd0, out_valid}, 32'd1);
    end

    // Redirect while holding pc 0 and 4
    out_ready = 1'b0;
    do_reset();
    expect_from(32'h0, 2);
    step(); step(); step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    sb.delete();
    expect_from(32'h8, 8);
    check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h8);
    step();
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h8);
    check("redir_instr", out_instr, 32'h0020_81b3);
    out_ready = 1'b1;
    step(); step(); step();

    // Redirect legality table
    for (int v = 0; v < 7; v++) begin
      redirect_valid = 1'b1;
      redirect_pc = rtab[v].rpc;
      step();
      redirect_valid = 1'b0;
      sb.delete();
      fc = fetch_count;
      check("tab_fault", {31'd0, fault}, {31'd0, rtab[v].exp_fault});
      check("tab_addr", imem_addr, rtab[v].rpc);
      check("tab_flush", {31'd0, out_valid}, 32'd0);
      if (!rtab[v].exp_fault) begin
        expect_from(rtab[v].rpc, 4);
        repeat (4) step();
        check("tab_fcount_run", fetch_count, fc + 32'd4);
        check("tab_fault_run", {31'd0, fault}, 32'd0);
      end else begin
        repeat (3) step();
        check("tab_fcount_frozen", fetch_count, fc);
        check("tab_fault_sticky", {31'd0, fault}, 32'd1);
        check("tab_valid_frozen", {31'd0, out_valid}, 32'd0);
        check("tab_addr_frozen", imem_addr, rtab[v].rpc);
      end
    end

    // Sequential overrun on a 4-word memory; main instance fills meanwhile
    out_ready = 1'b0;
    s_out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("ovr_valid", {31'd0, s_out_valid}, 32'd1);
      check("ovr_pc", s_out_pc, 32'(4 * i));
      check("ovr_instr", s_out_instr, img(30'(i)));
    end
    step();
    check("ovr_fault", {31'd0, s_fault}, 32'd1);
    check("ovr_addr", s_imem_addr, 32'd16);
    check("ovr_valid_end", {31'd0, s_out_valid}, 32'd0);
    repeat (2) step();
    check("ovr_no_more", {31'd0, s_out_valid}, 32'd0);
    check("ovr_fcount", s_fetch_count, 32'd4);

    // Asynchronous reset between edges
    check("pre_arst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_arst_fcount", fetch_count, 32'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_instr", out_instr, 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_fcount", fetch_count, 32'd0);
    check("arst_addr", imem_addr, 32'd0);
    check("arst_small_fault", {31'd0, s_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
